sha512_pad: RTL and testbench
=============================

Name: sha512_pad

Overview:
- Padding stage that sits directly upstream of the SHA-512 compression engine.
- Pulls 64-bit big-endian message words, each with a byte mask, from the message FIFO.
- Forwards full message words, inserts the 0x80 marker byte, zero-fills, and appends the 128-bit message bit length.
- Output is a stream of exactly whole 1024-bit blocks (16 words each) over a valid/ready handshake.

Parameters:
- LenW, 128, width of the message bit-length field and of the internal sent-bit counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- sha_en_i  in  1  block enable; low aborts and idles the block
- hash_start_i  in  1  one-cycle pulse; begin a new message
- hash_process_i  in  1  one-cycle pulse; message complete, message_length_i is final
- message_length_i  in  LenW  total message bits pushed; a multiple of 8
- fifo_rvalid_i  in  1  FIFO word available
- fifo_rdata_i  in  72  sha_fifo_t: data[63:0] big-endian, mask[7:0] (MSB = first byte)
- fifo_rready_o  out  1  pop FIFO word
- shaf_rvalid_o  out  1  padded word valid to the engine
- shaf_rdata_o  out  64  padded word
- shaf_rready_i  in  1  engine accepts word
- pad_done_o  out  1  one-cycle pulse after the last length word is accepted
- err_o  out  1  mask/length mismatch pulse (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state StIdle; tx_count 0; process_flag 0.
- Internal state:
  - tx_count[LenW-1:0] adds 64 on every output handshake (shaf_rvalid_o && shaf_rready_i).
  - Word index = tx_count[9:6].
  - rem = message_length_i - tx_count, LenW-bit unsigned.
- Control inputs:
  - hash_start_i: clears tx_count and process_flag, goes to StFifoReceive.
  - hash_process_i: sets process_flag.
  - sha_en_i low overrides everything: next cycle is StIdle, counters and flags clear, outputs deasserted.
- StIdle:
  - shaf_rvalid_o = 0, fifo_rready_o = 0.
- StFifoReceive:
  - Ordinary word: condition is fifo_rvalid_i && mask==8'hFF && (!process_flag || rem>=64).
    - Combinational pass-through: shaf_rvalid_o = 1, shaf_rdata_o = data, fifo_rready_o = shaf_rready_i. Zero latency.
  - Final partial word: condition is process_flag && 0<rem<64 && fifo_rvalid_i.
    - n = rem[5:3] bytes.
    - Output keeps the top n data bytes, puts 0x80 in byte n, and zeros the remaining bytes.
    - Pop the FIFO on the handshake, then go to StPad00, or to StLenHi if the next index is 14.
  - process_flag && rem==0: go to StPad80; the FIFO is not popped.
  - Word with a partial mask while !process_flag: stall. Output invalid, no pop.
- StPad80:
  - Emit 64'h8000_0000_0000_0000.
  - On handshake, go to StLenHi if the next index is 14, else StPad00.
- StPad00:
  - Emit zeros while index != 14.
  - Wraps through index 15 into the next block when the marker landed at index 14 or 15.
  - Go to StLenHi when the post-handshake index is 14.
- StLenHi:
  - Emit message_length_i[127:64], then go to StLenLo.
- StLenLo:
  - Emit message_length_i[63:0].
  - On handshake, pulse pad_done_o and go to StIdle.
- Handshake rules:
  - In every padding state shaf_rvalid_o = 1 and shaf_rdata_o holds stable until accepted.
  - The state advances only on handshake.
- Simultaneous events:
  - hash_start_i and hash_process_i in the same cycle: both take effect.
  - hash_start_i outside StIdle restarts the message (sha_en_i still has priority).
- tx_count wraps modulo 2^LenW; no overflow detection.

Optional Feature:
- Macro SHA512_PAD_MASK_CHECK_EN.
- When defined:
  - Final partial word whose mask != the expected mask (top n bits set): err_o pulses one cycle on its handshake. Output data still follows message_length_i.
  - Final partial word consumed with mask==8'hFF: err_o pulses one cycle on that handshake.
- When undefined: err_o is tied to 0.

Decomposition:
- Add the following to hmac512_pkg; no sub-module:
  - typedef enum sha512_pad_st_e {StIdle, StFifoReceive, StPad80, StPad00, StLenHi, StLenLo}.
  - Constants PadMarker = 64'h8000_0000_0000_0000 and LenWordIdx = 4'd14.
  - Function pad_last_word(data, nbytes).
- Reuse sha_fifo_t and sha_word_t from the package.

Test Plan:
- Empty message: hash_start, hash_process, length 0 -> 16 words: 0x8000_0000_0000_0000, 15×0; pad_done_o pulses once.
- "abc": length 24, FIFO word 0x6162_6300_0000_0000 with mask 8'hE0 -> word0 0x6162_6380_0000_0000, words1-14 0, word15 0x18.
- 112-byte message (896 bits), 14 full words:
  - words 0-13 pass through; word14 = 0x8000_0000_0000_0000; word15 = 0.
  - Then 14 zero words, 0, 0x380: 32 words total.
- Random shaf_rready_i back-pressure, 1000-bit-multiple messages -> output identical to the no-stall run; data stable while valid && !ready.
- Abort: sha_en_i dropped at word 5, then hash_start with "abc" -> clean single "abc" block, tx_count restarted.
- SHA512_PAD_MASK_CHECK_EN: length 24, final mask 8'hF0 -> err_o pulses once; data 0x6162_6380_0000_0000 unchanged.

Source files
------------

// File: rtl/hmac512_pkg.sv
// Shared types and helpers for the HMAC/SHA-512 datapath: FIFO word format,
// padding-stage state encoding and the final-word padding function.
package hmac512_pkg;

    typedef logic [63:0] sha_word_t;

    // One message FIFO entry: big-endian data, byte mask with MSB = first byte.
    typedef struct packed {
        sha_word_t  data;
        logic [7:0] mask;
    } sha_fifo_t;

    typedef enum logic [2:0] {
        StIdle,
        StFifoReceive,
        StPad80,
        StPad00,
        StLenHi,
        StLenLo
    } sha512_pad_st_e;

    localparam sha_word_t  PadMarker  = 64'h8000_0000_0000_0000;
    localparam logic [3:0] LenWordIdx = 4'd14;

    // Keep the first nbytes bytes, put the 0x80 marker right after them, zero the rest.
    function automatic sha_word_t pad_last_word(sha_word_t data, logic [2:0] nbytes);
        sha_word_t w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(nbytes)) begin
                w[63-8*i -: 8] = data[63-8*i -: 8];
            end else if (i == int'(nbytes)) begin
                w[63-8*i -: 8] = 8'h80;
            end
        end
        return w;
    endfunction

    // Byte mask a well-formed final word with nbytes valid bytes must carry.
    function automatic logic [7:0] last_word_mask(logic [2:0] nbytes);
        return ~(8'hFF >> nbytes);
    endfunction

endpackage

// File: rtl/sha512_pad.sv
// SHA-512 message padding stage. Passes full message words straight from the
// FIFO to the compression engine, then inserts the 0x80 marker, zero fill and
// the 128-bit message bit length so the output is a whole number of
// 1024-bit blocks.
// Optional build macro: SHA512_PAD_MASK_CHECK_EN enables err_o, which flags a
// final partial word whose byte mask disagrees with message_length_i.
module sha512_pad
    import hmac512_pkg::*;
#(
    parameter int LenW = 128
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            sha_en_i,
    input  logic            hash_start_i,
    input  logic            hash_process_i,
    input  logic [LenW-1:0] message_length_i,
    input  logic            fifo_rvalid_i,
    input  sha_fifo_t       fifo_rdata_i,
    output logic            fifo_rready_o,
    output logic            shaf_rvalid_o,
    output sha_word_t       shaf_rdata_o,
    input  logic            shaf_rready_i,
    output logic            pad_done_o,
    output logic            err_o
);

    sha512_pad_st_e  state;
    logic [LenW-1:0] tx_count;
    logic            process_flag;

    logic [LenW-1:0] rem;
    logic [127:0]    len_128;
    logic [3:0]      idx_next;
    logic            rem_zero;
    logic            rem_partial;
    logic            last_word;
    logic            ordinary_word;
    logic            handshake;

    assign rem         = message_length_i - tx_count;
    assign len_128     = 128'(message_length_i);
    assign idx_next    = tx_count[9:6] + 4'd1;
    assign rem_zero    = (rem == '0);
    assign rem_partial = !rem_zero && (rem < LenW'(64));

    // The final partial word is only recognised once the length is known.
    assign last_word     = (state == StFifoReceive) && process_flag && rem_partial;
    assign ordinary_word = (state == StFifoReceive) && fifo_rvalid_i &&
                           (fifo_rdata_i.mask == 8'hFF) &&
                           (!process_flag || (!rem_zero && !rem_partial));

    // Output word selection; message words pass through with zero latency.
    always_comb begin
        shaf_rvalid_o = 1'b0;
        shaf_rdata_o  = '0;
        fifo_rready_o = 1'b0;
        if (sha_en_i) begin
            unique case (state)
                StFifoReceive: begin
                    if (last_word) begin
                        shaf_rvalid_o = fifo_rvalid_i;
                        shaf_rdata_o  = pad_last_word(fifo_rdata_i.data, rem[5:3]);
                        fifo_rready_o = fifo_rvalid_i && shaf_rready_i;
                    end else if (ordinary_word) begin
                        shaf_rvalid_o = 1'b1;
                        shaf_rdata_o  = fifo_rdata_i.data;
                        fifo_rready_o = shaf_rready_i;
                    end
                end
                StPad80: begin
                    shaf_rvalid_o = 1'b1;
                    shaf_rdata_o  = PadMarker;
                end
                StPad00: begin
                    shaf_rvalid_o = 1'b1;
                end
                StLenHi: begin
                    shaf_rvalid_o = 1'b1;
                    shaf_rdata_o  = len_128[127:64];
                end
                StLenLo: begin
                    shaf_rvalid_o = 1'b1;
                    shaf_rdata_o  = len_128[63:0];
                end
                default: ;
            endcase
        end
    end

    assign handshake = shaf_rvalid_o && shaf_rready_i;

    // Padding FSM, sent-word counter, process flag and done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= StIdle;
            tx_count     <= '0;
            process_flag <= 1'b0;
            pad_done_o   <= 1'b0;
        end else if (!sha_en_i) begin
            state        <= StIdle;
            tx_count     <= '0;
            process_flag <= 1'b0;
            pad_done_o   <= 1'b0;
        end else begin
            pad_done_o <= 1'b0;
            if (hash_start_i) begin
                tx_count     <= '0;
                process_flag <= hash_process_i;
                state        <= StFifoReceive;
            end else begin
                if (hash_process_i) begin
                    process_flag <= 1'b1;
                end
                if (handshake) begin
                    tx_count <= tx_count + LenW'(64);
                end
                unique case (state)
                    StFifoReceive: begin
                        if (last_word && handshake) begin
                            state <= (idx_next == LenWordIdx) ? StLenHi : StPad00;
                        end else if (process_flag && rem_zero) begin
                            state <= StPad80;
                        end
                    end
                    StPad80, StPad00: begin
                        if (handshake) begin
                            state <= (idx_next == LenWordIdx) ? StLenHi : StPad00;
                        end
                    end
                    StLenHi: begin
                        if (handshake) begin
                            state <= StLenLo;
                        end
                    end
                    StLenLo: begin
                        if (handshake) begin
                            pad_done_o <= 1'b1;
                            state      <= StIdle;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SHA512_PAD_MASK_CHECK_EN
    // Flag a consumed final word whose mask does not match the byte count from the length.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (!sha_en_i) begin
            err_o <= 1'b0;
        end else begin
            err_o <= last_word && handshake &&
                     (fifo_rdata_i.mask != last_word_mask(rem[5:3]));
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sha512_pad.sv
// Self-checking bench for sha512_pad: table of message lengths, hand-written
// corner sequences and random messages, all compared against a byte-level
// SHA-512 padding model.
module tb_sha512_pad;
    import hmac512_pkg::*;

`ifdef SHA512_PAD_MASK_CHECK_EN
    localparam int MaskChk = 1;
`else
    localparam int MaskChk = 0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         sha_en_i;
    logic         hash_start_i;
    logic         hash_process_i;
    logic [127:0] message_length_i;
    logic         fifo_rvalid_i;
    sha_fifo_t    fifo_rdata_i;
    logic         fifo_rready_o;
    logic         shaf_rvalid_o;
    logic [63:0]  shaf_rdata_o;
    logic         shaf_rready_i;
    logic         pad_done_o;
    logic         err_o;

    sha512_pad #(.LenW(128)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .sha_en_i         (sha_en_i),
        .hash_start_i     (hash_start_i),
        .hash_process_i   (hash_process_i),
        .message_length_i (message_length_i),
        .fifo_rvalid_i    (fifo_rvalid_i),
        .fifo_rdata_i     (fifo_rdata_i),
        .fifo_rready_o    (fifo_rready_o),
        .shaf_rvalid_o    (shaf_rvalid_o),
        .shaf_rdata_o     (shaf_rdata_o),
        .shaf_rready_i    (shaf_rready_i),
        .pad_done_o       (pad_done_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int nbytes;
        int rdy_pct;
        int exp_words;
    } vec_t;

    int           checks   = 0;
    int           failures = 0;
    byte unsigned msg_q[$];
    logic [71:0]  fifo_q[$];
    logic [63:0]  got_q[$];
    logic [63:0]  exp_q[$];
    logic [63:0]  ref_q[$];
    int           done_cnt;
    int           err_cnt;
    logic         hold_valid;
    logic [63:0]  hold_data;
    vec_t         vecs[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    // One clock cycle: drive inputs after the falling edge, sample outputs 1ns later.
    task automatic step(input int rdy_pct, input logic start, input logic process);
        @(negedge clk_i);
        hash_start_i   = start;
        hash_process_i = process;
        fifo_rvalid_i  = (fifo_q.size() != 0);
        fifo_rdata_i   = fifo_rvalid_i ? fifo_q[0] : '0;
        shaf_rready_i  = (int'($urandom_range(0, 99)) < rdy_pct);
        #1;
        if (pad_done_o) done_cnt++;
        if (err_o) err_cnt++;
        if (hold_valid)
            chk("hold_stable", 128'({shaf_rvalid_o, shaf_rdata_o}), 128'({1'b1, hold_data}));
        if (shaf_rvalid_o && shaf_rready_i) got_q.push_back(shaf_rdata_o);
        hold_valid = shaf_rvalid_o && !shaf_rready_i;
        hold_data  = shaf_rdata_o;
        if (fifo_rready_o && fifo_q.size() != 0) void'(fifo_q.pop_front());
    endtask

    // Pack msg_q into FIFO words; bytes past the message end are zero or random.
    task automatic load_msg(input int n, input bit garbage, input int mask_override);
        fifo_q.delete();
        for (int w = 0; w * 8 < n; w++) begin
            logic [63:0] d;
            logic [7:0]  m;
            int          k;
            d = '0;
            k = n - 8 * w;
            if (k > 8) k = 8;
            for (int b = 0; b < 8; b++) begin
                byte unsigned v;
                v = (b < k) ? msg_q[8*w+b] : (garbage ? 8'($urandom) : 8'h00);
                d = {d[55:0], v};
            end
            m = ~(8'hFF >> k);
            if (mask_override >= 0 && 8 * w + 8 >= n) m = 8'(mask_override);
            fifo_q.push_back({d, m});
        end
    endtask

    // Reference: message bytes, 0x80, zeros to 112 mod 128, 16-byte big-endian bit length.
    task automatic build_expected(input int n);
        byte unsigned b[$];
        logic [127:0] len;
        b   = msg_q;
        len = 128'(n) * 128'd8;
        b.push_back(8'h80);
        while ((b.size() % 128) != 112) b.push_back(8'h00);
        for (int i = 15; i >= 0; i--) b.push_back(len[8*i +: 8]);
        exp_q.delete();
        for (int w = 0; w < b.size() / 8; w++) begin
            logic [63:0] d;
            d = '0;
            for (int j = 0; j < 8; j++) d = {d[55:0], b[8*w+j]};
            exp_q.push_back(d);
        end
    endtask

    task automatic run_msg(input string tag, input int n, input int rdy_pct, input bit garbage,
                           input int mask_override, input int exp_err);
        got_q.delete();
        done_cnt   = 0;
        err_cnt    = 0;
        hold_valid = 1'b0;
        load_msg(n, garbage, mask_override);
        build_expected(n);
        message_length_i = 128'(n) * 128'd8;
        step(rdy_pct, 1'b1, 1'b1);
        for (int c = 0; c < 4000 && done_cnt == 0; c++) step(rdy_pct, 1'b0, 1'b0);
        step(100, 1'b0, 1'b0);
        step(100, 1'b0, 1'b0);
        chk({tag, " idle_after"}, 128'(shaf_rvalid_o), 128'(0));
        chk({tag, " pad_done_count"}, 128'(done_cnt), 128'(1));
        chk({tag, " word_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s word%0d", tag, i), 128'(got_at(i)), 128'(exp_q[i]));
        chk({tag, " err_count"}, 128'(err_cnt), 128'(exp_err));
        chk({tag, " fifo_drained"}, 128'(fifo_q.size()), 128'(0));
    endtask

    task automatic set_abc();
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
    endtask

    task automatic set_random(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        rst_i            = 1'b1;
        sha_en_i         = 1'b1;
        hash_start_i     = 1'b0;
        hash_process_i   = 1'b0;
        message_length_i = '0;
        fifo_rvalid_i    = 1'b0;
        fifo_rdata_i     = '0;
        shaf_rready_i    = 1'b0;
        hold_valid       = 1'b0;
        hold_data        = '0;
        done_cnt         = 0;
        err_cnt          = 0;

        vecs[0] = '{0,   100, 16};
        vecs[1] = '{3,   60,  16};
        vecs[2] = '{8,   100, 16};
        vecs[3] = '{111, 70,  16};
        vecs[4] = '{112, 100, 32};
        vecs[5] = '{119, 50,  32};
        vecs[6] = '{127, 80,  32};
        vecs[7] = '{128, 100, 32};
        vecs[8] = '{125, 40,  32};
        vecs[9] = '{250, 65,  48};

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst shaf_rvalid", 128'(shaf_rvalid_o), 128'(0));
        chk("rst fifo_rready", 128'(fifo_rready_o), 128'(0));
        chk("rst pad_done", 128'(pad_done_o), 128'(0));
        chk("rst err", 128'(err_o), 128'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        fifo_q.push_back({64'h0123_4567_89AB_CDEF, 8'hFF});
        step(100, 1'b0, 1'b0);
        chk("idle shaf_rvalid", 128'(shaf_rvalid_o), 128'(0));
        chk("idle fifo_rready", 128'(fifo_rready_o), 128'(0));

        // Empty message
        msg_q.delete();
        run_msg("empty", 0, 100, 1'b0, -1, 0);
        chk("empty w0", 128'(got_at(0)), 128'(64'h8000_0000_0000_0000));
        chk("empty w15", 128'(got_at(15)), 128'(0));
        chk("empty size", 128'(got_q.size()), 128'(16));

        // "abc"
        set_abc();
        run_msg("abc", 3, 100, 1'b0, -1, 0);
        chk("abc w0", 128'(got_at(0)), 128'(64'h6162_6380_0000_0000));
        chk("abc w15", 128'(got_at(15)), 128'(64'h18));

        // 112-byte message: marker lands at index 14, length in the second block
        set_random(112);
        run_msg("m112", 112, 100, 1'b1, -1, 0);
        chk("m112 w14", 128'(got_at(14)), 128'(64'h8000_0000_0000_0000));
        chk("m112 w15", 128'(got_at(15)), 128'(0));
        chk("m112 w31", 128'(got_at(31)), 128'(64'h380));
        chk("m112 size", 128'(got_q.size()), 128'(32));

        // Length table
        for (int v = 0; v < 10; v++) begin
            set_random(vecs[v].nbytes);
            run_msg($sformatf("tbl%0d", v), vecs[v].nbytes, vecs[v].rdy_pct, 1'b1, -1, 0);
            chk($sformatf("tbl%0d words", v), 128'(got_q.size()), 128'(vecs[v].exp_words));
        end

        // Back-pressure gives the same stream as a stall-free run
        set_random(125);
        run_msg("bp_ref", 125, 100, 1'b0, -1, 0);
        ref_q = got_q;
        run_msg("bp_stall", 125, 35, 1'b1, -1, 0);
        chk("bp size", 128'(got_q.size()), 128'(ref_q.size()));
        for (int i = 0; i < ref_q.size(); i++)
            chk($sformatf("bp word%0d", i), 128'(got_at(i)), 128'(ref_q[i]));

        // Abort mid-message, then a clean "abc"
        set_random(64);
        got_q.delete();
        done_cnt   = 0;
        hold_valid = 1'b0;
        load_msg(64, 1'b0, -1);
        message_length_i = 128'd512;
        step(100, 1'b1, 1'b1);
        for (int c = 0; c < 200 && got_q.size() < 5; c++) step(100, 1'b0, 1'b0);
        chk("abort pre_words", 128'(got_q.size()), 128'(5));
        hold_valid = 1'b0;
        sha_en_i   = 1'b0;
        step(100, 1'b0, 1'b0);
        chk("abort shaf_rvalid", 128'(shaf_rvalid_o), 128'(0));
        chk("abort fifo_rready", 128'(fifo_rready_o), 128'(0));
        step(100, 1'b0, 1'b0);
        sha_en_i = 1'b1;
        step(100, 1'b0, 1'b0);
        chk("abort idle_rvalid", 128'(shaf_rvalid_o), 128'(0));
        chk("abort pad_done", 128'(done_cnt), 128'(0));
        set_abc();
        run_msg("abort_abc", 3, 100, 1'b0, -1, 0);
        chk("abort_abc w0", 128'(got_at(0)), 128'(64'h6162_6380_0000_0000));
        chk("abort_abc w15", 128'(got_at(15)), 128'(64'h18));

        // Final word with a wrong mask, and with a full mask
        set_abc();
        run_msg("mask_f0", 3, 100, 1'b0, 8'hF0, MaskChk);
        chk("mask_f0 w0", 128'(got_at(0)), 128'(64'h6162_6380_0000_0000));
        set_abc();
        run_msg("mask_ff", 3, 70, 1'b0, 8'hFF, MaskChk);
        chk("mask_ff w0", 128'(got_at(0)), 128'(64'h6162_6380_0000_0000));

        // Random messages under random back-pressure
        for (int r = 0; r < 20; r++) begin
            int n;
            int rdy;
            n   = int'($urandom_range(0, 300));
            rdy = int'($urandom_range(30, 100));
            set_random(n);
            run_msg($sformatf("rnd%0d_len%0d", r, n), n, rdy, 1'b1, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
